// File: rtl/oa_packer.sv
// oa_packer: packs requantized array elements little-endian into 32-bit words
// with a byte mask and a row-end flag, driving the output-activation writer.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   init_cfg, k, m     latch columns-per-row (k) and rows-per-tile (m)
//   start              begin packing one tile (honoured only when idle)
//   in_valid/in_ready  element handshake, in_data is one element
//   output_valid/output_ready/output_data/output_mask/switch_row
//                      packed word handshake toward the writer
//   busy               packer is not idle
//   tile_done          one-cycle pulse after a tile's final word is taken
//   stall_cycles       (OA_PACKER_STALL_CNT_EN only) saturating count of
//                      cycles with a word waiting on the writer
//
// Build option: define OA_PACKER_STALL_CNT_EN to add stall_cycles.
module oa_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_cfg,
  input  logic [REG_WIDTH-1:0]  k,
  input  logic [REG_WIDTH-1:0]  m,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [31:0]           output_data,
  output logic [3:0]            output_mask,
  output logic                  switch_row,
  output logic                  busy,
  output logic                  tile_done
`ifdef OA_PACKER_STALL_CNT_EN
  ,
  output logic [REG_WIDTH-1:0]  stall_cycles
`endif
);

  localparam int LANES = 32 / DATA_WIDTH;
  localparam int LIW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BPL   = DATA_WIDTH / 8;
  localparam logic [REG_WIDTH-1:0] ONE = REG_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DRAIN
  } state_t;

  state_t state;
  state_t state_next;

  logic [REG_WIDTH-1:0] cfg_k;
  logic [REG_WIDTH-1:0] cfg_m;
  logic [REG_WIDTH-1:0] wk;
  logic [REG_WIDTH-1:0] wm;
  logic [REG_WIDTH-1:0] col;
  logic [REG_WIDTH-1:0] row;
  logic [LIW-1:0]       lane;
  logic [31:0]          acc;

  logic        take;
  logic        out_take;
  logic        col_last;
  logic        row_last;
  logic        lane_last;
  logic        emit;
  logic        start_go;
  logic        start_nil;
  logic        done_c;
  logic [31:0] acc_new;
  logic [31:0] data_new;
  logic [3:0]  mask_new;

  assign busy      = (state != IDLE);
  assign in_ready  = (state == PACK) &&
                     (!output_valid || output_ready);
  assign take      = in_valid && in_ready;
  assign out_take  = output_valid && output_ready;
  assign col_last  = (col == wk - ONE);
  assign row_last  = (row == wm - ONE);
  assign lane_last = (lane == LIW'(LANES - 1));
  assign emit      = take && (lane_last || col_last);

  always_comb begin
    state_next = state;
    start_go   = 1'b0;
    start_nil  = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (cfg_k != '0 && cfg_m != '0) begin
            start_go   = 1'b1;
            state_next = PACK;
          end else begin
            start_nil  = 1'b1;
          end
        end
      end
      PACK: begin
        if (take && col_last && row_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_take) begin
          done_c     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Merge the incoming element into its lane, then zero every byte
  // that belongs to a lane above the current one.
  always_comb begin
    acc_new  = acc;
    data_new = '0;
    mask_new = '0;
    for (int i = 0; i < LANES; i++) begin
      if (LIW'(i) == lane) begin
        acc_new[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end
    end
    for (int b = 0; b < 4; b++) begin
      mask_new[b] = ((b / BPL) <= int'(lane));
      data_new[b*8 +: 8] = mask_new[b] ? acc_new[b*8 +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_k <= '0;
      cfg_m <= '0;
    end else if (init_cfg) begin
      cfg_k <= k;
      cfg_m <= m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wk   <= '0;
      wm   <= '0;
      col  <= '0;
      row  <= '0;
      lane <= '0;
      acc  <= '0;
    end else if (start_go) begin
      wk   <= cfg_k;
      wm   <= cfg_m;
      col  <= '0;
      row  <= '0;
      lane <= '0;
      acc  <= '0;
    end else if (take) begin
      if (emit) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + 1'b1;
        acc  <= acc_new;
      end
      if (col_last) begin
        col <= '0;
        row <= row + ONE;
      end else begin
        col <= col + ONE;
      end
    end
  end

  // A reload in the same cycle as an accept keeps output_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_valid <= 1'b0;
      output_data  <= '0;
      output_mask  <= '0;
      switch_row   <= 1'b0;
    end else if (emit) begin
      output_valid <= 1'b1;
      output_data  <= data_new;
      output_mask  <= mask_new;
      switch_row   <= col_last;
    end else if (out_take) begin
      output_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_done <= 1'b0;
    end else begin
      tile_done <= done_c || start_nil;
    end
  end

`ifdef OA_PACKER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (start_go || start_nil) begin
      stall_cycles <= '0;
    end else if (output_valid && !output_ready &&
                 stall_cycles != '1) begin
      stall_cycles <= stall_cycles + ONE;
    end
  end
`endif

endmodule
